// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the cacheline arbiter: FSM state encoding and requester-select values.
package arbiter_types;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/cacheline_arbiter.sv
// Shares one cacheline adapter between the icache and dcache; one requester owns the
// adapter from grant until its ca_resp, with a mandatory IDLE cycle between grants.
module cacheline_arbiter
    import arbiter_types::*;
#(
    parameter int unsigned s_line      = 256,
    parameter bit          round_robin = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [31:0]       i_addr,
    input  logic [s_line-1:0] i_wdata,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_addr,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,

    output logic              ca_read,
    output logic              ca_write,
    output logic [31:0]       ca_addr,
    output logic [s_line-1:0] ca_wdata,
    input  logic [s_line-1:0] ca_rdata,
    input  logic              ca_resp
);

    arb_state_t state_q, state_d;
    logic       last_d_q, last_d_d;
    logic       i_pend, d_pend, pick_dcache;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= SEL_I;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        ca_read  = 1'b0;
        ca_write = 1'b0;
        ca_addr  = '0;
        ca_wdata = '0;
        i_rdata  = '0;
        i_resp   = 1'b0;
        d_rdata  = '0;
        d_resp   = 1'b0;

        i_pend = i_read | i_write;
        d_pend = d_read | d_write;
        // On contention, round robin favours whoever was not served last.
        pick_dcache = round_robin ? (last_d_q == SEL_I) : 1'b1;

        unique case (state_q)
            IDLE: begin
                if (i_pend && d_pend) begin
                    state_d = pick_dcache ? SERVE_D : SERVE_I;
                end else if (d_pend) begin
                    state_d = SERVE_D;
                end else if (i_pend) begin
                    state_d = SERVE_I;
                end
            end
            SERVE_I: begin
                ca_write = i_write;
                ca_read  = i_read & ~i_write;
                ca_addr  = i_addr;
                ca_wdata = i_wdata;
                if (ca_resp) begin
                    i_resp   = 1'b1;
                    i_rdata  = ca_rdata;
                    state_d  = IDLE;
                    last_d_d = SEL_I;
                end
            end
            SERVE_D: begin
                ca_write = d_write;
                ca_read  = d_read & ~d_write;
                ca_addr  = d_addr;
                ca_wdata = d_wdata;
                if (ca_resp) begin
                    d_resp   = 1'b1;
                    d_rdata  = ca_rdata;
                    state_d  = IDLE;
                    last_d_d = SEL_D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
